axilite_regfile: RTL and testbench
==================================

// Module: axilite_regfile
// PURPOSE
//  AXI4-Lite slave register file; the DUT stage between master and slave agent benches.
//  Consumes the master-side axilite_if channels and provides NUM_REGS word registers.
//  Register 0 is a read-only ID word; the rest are read/write with byte strobes.
//  One outstanding write and one outstanding read; the AW and W channels are accepted independently.
// PARAMETERS
//  ADDR_WIDTH  10            byte address width
//  DATA_WIDTH  32            data width; only 32 supported (elaboration error otherwise)
//  NUM_REGS    16            number of word registers, 2..2**(ADDR_WIDTH-2)
//  ID_VALUE    32'hCAFE_0001 constant read value of register 0
// PORTS
//  aclk     in   1             clock, rising edge
//  aresetn  in   1             synchronous active-low reset
//  awaddr   in   ADDR_WIDTH    write address
//  awvalid  in   1             write address valid
//  awready  out  1             write address ready
//  wdata    in   DATA_WIDTH    write data
//  wstrb    in   DATA_WIDTH/8  write byte strobes
//  wvalid   in   1             write data valid
//  wready   out  1             write data ready
//  bresp    out  2             write response: 2'b00 OKAY, 2'b10 SLVERR
//  bvalid   out  1             write response valid
//  bready   in   1             write response ready
//  araddr   in   ADDR_WIDTH    read address
//  arvalid  in   1             read address valid
//  arready  out  1             read address ready
//  rdata    out  DATA_WIDTH    read data
//  rresp    out  2             read response
//  rvalid   out  1             read data valid
//  rready   in   1             read data ready
// BEHAVIOUR
//  - Reset (aresetn=0 at an edge): all outputs 0, registers 1..NUM_REGS-1 cleared, AW/W holding cleared.
//    Reset mid-transaction discards all pending state; no response is issued for it.
//  - All outputs are registered. awready, wready and arready rise on the first edge with aresetn=1.
//  - Decode: idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. idx>=NUM_REGS -> SLVERR.
//  - Write path, per channel: awready=1 while no AW held and bvalid=0; wready=1 while no W held and bvalid=0.
//    - A handshake (valid & ready at an edge) captures that channel into its holding register; ready then drops.
//    - At the edge where the second of AW/W is captured (or both together), the commit happens:
//      byte lane i of reg[idx] <= wdata[8i+7:8i] if wstrb[i].
//    - bvalid=1 from that edge: 1-cycle latency from the last handshake.
//    - Commit to idx 0: write ignored, bresp=OKAY. Out of range: no write, bresp=SLVERR. wstrb=0: no change, OKAY.
//    - bvalid and bresp are held stable until bready=1 at an edge. bvalid then clears, both holding registers
//      clear, and awready/wready rise that same edge.
//  - Read path: arready = registered !rvalid.
//    - On an AR handshake: rdata <= reg[idx] (ID_VALUE for idx 0; 0 with rresp=SLVERR if out of range), rvalid <= 1.
//    - rdata, rresp and rvalid are held until rready=1 at an edge; rvalid clears and arready rises at that edge.
//    - Max throughput is one read per 2 cycles.
//  - Read and write are fully independent. A same-edge AR handshake and write commit to the same idx returns
//    the pre-write value.
//  - No timeouts; valid inputs may stay asserted indefinitely without loss.
// TESTING
//  - Reset, then read idx0 (araddr=0x000) -> rvalid next cycle, rdata=32'hCAFE_0001, rresp=00.
//  - AW and W same cycle: awaddr=0x004, wdata=32'h1234_5678, wstrb=4'hF -> bvalid next cycle, bresp=00;
//    read 0x004 -> 32'h1234_5678.
//  - W 3 cycles before AW: wdata=32'hAABB_CCDD, wstrb=4'b0101, awaddr=0x004 (holding 32'h1234_5678)
//    -> wready low until B done; readback 32'h12BB_56DD.
//  - awaddr=0x040 (idx16) and araddr=0x3FC -> bresp=10, rresp=10, rdata=0; no register changes.
//  - bready held low 5 cycles -> bvalid/bresp stable; awready=wready=0 throughout; a second AW is accepted only
//    after the bready edge.
//  - Assert aresetn=0 with AW captured and rvalid=1 -> all outputs 0 next edge; idx1 reads 0 after reset.

Source files
------------

// File: rtl/axilite_regfile.sv
// AXI4-Lite slave register file: register 0 is a constant ID word, the rest are
// byte-strobed read/write words. One outstanding write and one outstanding read.
module axilite_regfile #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hCAFE_0001
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axilite_regfile supports only DATA_WIDTH=32");
  end
  if (NUM_REGS < 2 || NUM_REGS > 2**IW) begin : g_bad_regs
    $error("axilite_regfile NUM_REGS out of range");
  end

  // Handshake rule on every channel: a transfer happens at a rising edge where
  // valid and ready are both 1; the source holds its payload until then.
  logic [31:0] regs [1:NUM_REGS-1];

  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;

  logic          aw_hs, w_hs, b_done, commit;
  logic          aw_held_n, w_held_n, bvalid_n;
  logic [IW-1:0] c_idx, ar_idx;
  logic [31:0]   c_data, rd_val;
  logic [3:0]    c_strb;
  logic          ar_hs, r_done, rvalid_n;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_done = bvalid & bready;
  // Commit fires at the edge where the second of AW/W arrives (or both together).
  assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;
  assign c_idx  = aw_held ? aw_idx : awaddr[ADDR_WIDTH-1:2];
  assign c_data = w_held ? w_data : wdata;
  assign c_strb = w_held ? w_strb : wstrb;

  assign aw_held_n = b_done ? 1'b0 : (aw_held | aw_hs);
  assign w_held_n  = b_done ? 1'b0 : (w_held | w_hs);
  assign bvalid_n  = b_done ? 1'b0 : (bvalid | commit);

  assign ar_hs    = arvalid & arready;
  assign r_done   = rvalid & rready;
  assign rvalid_n = ar_hs ? 1'b1 : (r_done ? 1'b0 : rvalid);
  assign ar_idx   = araddr[ADDR_WIDTH-1:2];

  always_comb begin
    rd_val = '0;
    if (ar_idx == '0) rd_val = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) rd_val = regs[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      if (aw_hs) aw_idx <= awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      awready <= ~aw_held_n & ~bvalid_n;
      wready  <= ~w_held_n & ~bvalid_n;
      bvalid  <= bvalid_n;
      if (commit) begin
        bresp <= ({1'b0, c_idx} < (IW+1)'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
        for (int i = 1; i < NUM_REGS; i++) begin
          for (int b = 0; b < 4; b++) begin
            if (c_idx == IW'(i) && c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
      rvalid  <= rvalid_n;
      arready <= ~rvalid_n;
      if (ar_hs) begin
        rdata <= rd_val;
        rresp <= ({1'b0, ar_idx} < (IW+1)'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axilite_regfile.sv
// Directed bench for axilite_regfile: hand-computed expected values checked
// one sample after each rising edge.
module tb_axilite_regfile;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;

  axilite_regfile dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_go, w_go;
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (n = 0; n < 20; n++) begin
      aw_go = awvalid & awready;
      w_go  = wvalid & wready;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid = 1'b0;
      if (bvalid) break;
    end
    if (n == 20) check("bvalid_timeout", 32'(bvalid), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    araddr = addr;
    arvalid = 1'b1;
    for (n = 0; n < 20 && !arready; n++) step();
    if (n == 20) check("arready_timeout", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
    check("rvalid_latency", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
    repeat (3) step();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    aresetn = 1'b1;
    step();
    check("rise_awready", 32'(awready), 32'd1);
    check("rise_wready", 32'(wready), 32'd1);
    check("rise_arready", 32'(arready), 32'd1);

    // ID register
    axi_read(10'h000, d, r);
    check("id_data", d, 32'hCAFE_0001);
    check("id_resp", 32'(r), 32'd0);

    // AW and W together
    awaddr = 10'h004; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    check("aww_bvalid", 32'(bvalid), 32'd1);
    check("aww_bresp", 32'(bresp), 32'd0);
    check("aww_awready", 32'(awready), 32'd0);
    bready = 1;
    step();
    bready = 0;
    check("aww_bclear", 32'(bvalid), 32'd0);
    check("aww_ready_back", 32'({awready, wready}), 32'd3);
    axi_read(10'h004, d, r);
    check("reg1_full", d, 32'h1234_5678);

    // W three cycles ahead of AW
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1;
    step();
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("wfirst_wready", 32'(wready), 32'd0);
      check("wfirst_nobvalid", 32'(bvalid), 32'd0);
      if (i < 2) step();
    end
    awaddr = 10'h004; awvalid = 1;
    step();
    awvalid = 0;
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_wready_b", 32'(wready), 32'd0);
    bready = 1;
    step();
    bready = 0;
    axi_read(10'h004, d, r);
    check("reg1_strobed", d, 32'h12BB_56DD);

    // Out of range write and read
    axi_write(10'h040, 32'hFFFF_FFFF, 4'hF, r);
    check("oor_bresp", 32'(r), 32'd2);
    axi_read(10'h3FC, d, r);
    check("oor_rresp", 32'(r), 32'd2);
    check("oor_rdata", d, 32'd0);
    axi_read(10'h03C, d, r);
    check("idx15_data", d, 32'd0);
    check("idx15_resp", 32'(r), 32'd0);
    axi_read(10'h004, d, r);
    check("reg1_unchanged", d, 32'h12BB_56DD);

    // Writes to ID and with empty strobes
    axi_write(10'h000, 32'h0BAD_F00D, 4'hF, r);
    check("id_write_resp", 32'(r), 32'd0);
    axi_read(10'h000, d, r);
    check("id_kept", d, 32'hCAFE_0001);
    axi_write(10'h008, 32'hDEAD_BEEF, 4'hF, r);
    axi_write(10'h008, 32'h0000_0000, 4'h0, r);
    check("nostrb_resp", 32'(r), 32'd0);
    axi_read(10'h00B, d, r);
    check("nostrb_kept", d, 32'hDEAD_BEEF);

    // bready held low, second AW/W waits
    awaddr = 10'h00C; wdata = 32'h1111_2222; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awaddr = 10'h010; wdata = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(bvalid), 32'd1);
      check("bhold_bresp", 32'(bresp), 32'd0);
      check("bhold_ready", 32'({awready, wready}), 32'd0);
      step();
    end
    bready = 1;
    step();
    bready = 0;
    check("bhold_release", 32'({bvalid, awready, wready}), 32'b011);
    step();
    awvalid = 0; wvalid = 0;
    check("second_bvalid", 32'(bvalid), 32'd1);
    bready = 1;
    step();
    bready = 0;
    axi_read(10'h00C, d, r);
    check("reg3", d, 32'h1111_2222);
    axi_read(10'h010, d, r);
    check("reg4", d, 32'h3333_4444);

    // Same-edge read and write commit to idx5
    awaddr = 10'h014; wdata = 32'h0000_0055; wstrb = 4'hF; araddr = 10'h014;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("race_rvalid", 32'(rvalid), 32'd1);
    check("race_old", rdata, 32'd0);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    axi_read(10'h014, d, r);
    check("race_new", d, 32'h0000_0055);

    // Reset with AW held and read data pending
    awaddr = 10'h004; awvalid = 1;
    step();
    awvalid = 0;
    araddr = 10'h000; arvalid = 1;
    step();
    arvalid = 0;
    check("pre_rst_state", 32'({awready, rvalid}), 32'b01);
    aresetn = 0;
    step();
    check("mid_rst_ready", 32'({awready, wready, arready}), 32'd0);
    check("mid_rst_valid", 32'({bvalid, rvalid}), 32'd0);
    check("mid_rst_resp", 32'({bresp, rresp}), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    aresetn = 1;
    step();
    axi_read(10'h004, d, r);
    check("reg1_after_rst", d, 32'd0);
    // AW holding must be gone: a lone W must not commit
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1;
    step();
    wvalid = 0;
    step();
    check("no_stale_aw", 32'(bvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
